// File: rtl/vs_fp_mat_vec_sequencer_pkg.sv
// Shared fixed-point types and geometry helpers for the matrix-vector sequencer
// and its systolic array.
package vs_fp_mat_vec_sequencer_pkg;

    typedef logic signed [31:0] fp_32_t;
    typedef logic signed [63:0] fp_64_t;

    // Number of band-diagonal cells in an N x N square systolic array.
    function automatic int vs_num_bands(input int n);
        return (32'sd2 * n) - 32'sd1;
    endfunction

endpackage

// File: rtl/vs_fp_square_matrix_vector_mul_array.sv
// Linear systolic array: y(t) = sum_i a_i(t-1-i) * x(t-1-2i), accumulated in
// 64 bits and scaled by >>> Q at the output.
module vs_fp_square_matrix_vector_mul_array
    import vs_fp_mat_vec_sequencer_pkg::*;
#(
    parameter int Q = 15,
    parameter int N = 4
) (
    input  logic   clock,
    input  logic   reset_n,
    input  fp_32_t a_in [2*N-1],
    input  fp_32_t x_in,
    output fp_32_t y_out
);

    localparam int NB = vs_num_bands(N);

    fp_64_t psum_r    [NB];
    fp_32_t x_dly_r   [NB-1];
    fp_32_t x_tap_s   [NB];
    fp_64_t psum_in_s [NB];

    // Cell i sees x delayed by i cycles and the partial sum of cell i+1.
    always_comb begin
        x_tap_s[0] = x_in;
        for (int i = 1; i < NB; i++) begin
            x_tap_s[i] = x_dly_r[i-1];
        end
        psum_in_s[NB-1] = '0;
        for (int i = 0; i < NB - 1; i++) begin
            psum_in_s[i] = psum_r[i+1];
        end
    end

    // x delay line and partial-sum chain flowing towards cell 0.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < NB - 1; i++) begin
                x_dly_r[i] <= '0;
            end
            for (int i = 0; i < NB; i++) begin
                psum_r[i] <= '0;
            end
        end else begin
            x_dly_r[0] <= x_in;
            for (int i = 1; i < NB - 1; i++) begin
                x_dly_r[i] <= x_dly_r[i-1];
            end
            for (int i = 0; i < NB; i++) begin
                psum_r[i] <= psum_in_s[i] + (fp_64_t'(a_in[i]) * fp_64_t'(x_tap_s[i]));
            end
        end
    end

    assign y_out = fp_32_t'(psum_r[0] >>> Q);

endmodule

// File: rtl/vs_fp_mat_vec_sequencer.sv
// Owns the A/x stores, skews them into the systolic array's band inputs and
// captures each row result into an indexed result stream.
module vs_fp_mat_vec_sequencer
    import vs_fp_mat_vec_sequencer_pkg::*;
#(
    parameter int Q = 15,
    parameter int N = 4
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 mat_wr_en,
    input  logic [$clog2(N)-1:0] mat_wr_row,
    input  logic [$clog2(N)-1:0] mat_wr_col,
    input  logic [31:0]          mat_wr_data,
    input  logic                 vec_wr_en,
    input  logic [$clog2(N)-1:0] vec_wr_idx,
    input  logic [31:0]          vec_wr_data,
    input  logic                 start,
    output logic                 busy,
    output logic                 y_valid,
    output logic [$clog2(N)-1:0] y_idx,
    output logic [31:0]          y_data,
    output logic                 y_last,
    output logic                 done
);

    localparam int IW = $clog2(N);
    localparam int TW = $clog2(4*N-1);
    localparam int NB = vs_num_bands(N);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]    state_r;
    logic [TW-1:0] tau_r;
    fp_32_t        mat_r [N][N];
    fp_32_t        vec_r [N];
    fp_32_t        a_in_s [NB];
    fp_32_t        x_in_s;
    fp_32_t        y_out_s;
    logic          y_valid_r;
    logic [IW-1:0] y_idx_r;
    fp_32_t        y_data_r;
    logic          y_last_r;
    logic          done_r;
    int            row_s;
    int            col_s;

    // Run control: tau counts 0..4N-2 during RUN and rests at 0 in IDLE.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
            tau_r   <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    tau_r <= '0;
                    if (start) begin
                        state_r <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (tau_r == TW'(4*N-2)) begin
                        state_r <= ST_IDLE;
                        tau_r   <= '0;
                    end else begin
                        tau_r <= tau_r + TW'(1);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    tau_r   <= '0;
                end
            endcase
        end
    end

    // Store writes land only while idle, so a running product never sees them.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int r = 0; r < N; r++) begin
                vec_r[r] <= '0;
                for (int c = 0; c < N; c++) begin
                    mat_r[r][c] <= '0;
                end
            end
        end else if (state_r == ST_IDLE) begin
            if (mat_wr_en) begin
                mat_r[mat_wr_row][mat_wr_col] <= fp_32_t'(mat_wr_data);
            end
            if (vec_wr_en) begin
                vec_r[vec_wr_idx] <= fp_32_t'(vec_wr_data);
            end
        end
    end

    // Band skew: cell i carries A[k-(N-1)][k-i] with k=(tau+i)/2 on even phases.
    always_comb begin
        x_in_s = '0;
        row_s  = 32'sd0;
        col_s  = 32'sd0;
        for (int i = 0; i < NB; i++) begin
            a_in_s[i] = '0;
        end
        if (state_r == ST_RUN) begin
            if (!tau_r[0] && ((int'(tau_r) / 2) < N)) begin
                x_in_s = vec_r[IW'(int'(tau_r) / 2)];
            end else begin
                x_in_s = '0;
            end
            for (int i = 0; i < NB; i++) begin
                row_s = ((int'(tau_r) + i) / 2) - (N - 1);
                col_s = ((int'(tau_r) + i) / 2) - i;
                if ((((int'(tau_r) + i) % 2) == 0) && (row_s >= 0) && (row_s < N) &&
                    (col_s >= 0) && (col_s < N)) begin
                    a_in_s[i] = mat_r[IW'(row_s)][IW'(col_s)];
                end else begin
                    a_in_s[i] = '0;
                end
            end
        end else begin
            x_in_s = '0;
        end
    end

    vs_fp_square_matrix_vector_mul_array #(
        .Q (Q),
        .N (N)
    ) u_array (
        .clock   (clock),
        .reset_n (reset_n),
        .a_in    (a_in_s),
        .x_in    (x_in_s),
        .y_out   (y_out_s)
    );

    // Row r leaves the array at tau = 2N-1+2r; register it one cycle later.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            y_valid_r <= 1'b0;
            y_idx_r   <= '0;
            y_data_r  <= '0;
            y_last_r  <= 1'b0;
            done_r    <= 1'b0;
        end else if ((state_r == ST_RUN) && tau_r[0] && (int'(tau_r) >= (2*N-1))) begin
            y_valid_r <= 1'b1;
            y_idx_r   <= IW'((int'(tau_r) - (2*N-1)) / 2);
            y_data_r  <= y_out_s;
            y_last_r  <= (tau_r == TW'(4*N-3));
            done_r    <= (tau_r == TW'(4*N-3));
        end else begin
            y_valid_r <= 1'b0;
            y_last_r  <= 1'b0;
            done_r    <= 1'b0;
        end
    end

    assign busy    = (state_r == ST_RUN);
    assign y_valid = y_valid_r;
    assign y_idx   = y_idx_r;
    assign y_data  = y_data_r;
    assign y_last  = y_last_r;
    assign done    = done_r;

endmodule

// File: tb/tb_vs_fp_mat_vec_sequencer.sv
// Scoreboard bench: stimulus pushes golden row results (with expected cycle),
// a negedge monitor pops and compares whenever y_valid is seen.
module tb_vs_fp_mat_vec_sequencer;
    import vs_fp_mat_vec_sequencer_pkg::*;

    localparam int Q = 15;
    localparam int N = 4;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        mat_wr_en = 1'b0;
    logic [1:0]  mat_wr_row = 2'd0;
    logic [1:0]  mat_wr_col = 2'd0;
    logic [31:0] mat_wr_data = 32'd0;
    logic        vec_wr_en = 1'b0;
    logic [1:0]  vec_wr_idx = 2'd0;
    logic [31:0] vec_wr_data = 32'd0;
    logic        start = 1'b0;
    logic        busy, y_valid, y_last, done;
    logic [1:0]  y_idx;
    logic [31:0] y_data;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int bc;

    fp_32_t a_m [N][N];
    fp_32_t x_m [N];

    typedef struct {
        int          idx;
        logic [31:0] data;
        bit          last;
        int          cyc;
    } exp_t;
    exp_t sb_q [$];

    vs_fp_mat_vec_sequencer #(.Q(Q), .N(N)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .mat_wr_en   (mat_wr_en),
        .mat_wr_row  (mat_wr_row),
        .mat_wr_col  (mat_wr_col),
        .mat_wr_data (mat_wr_data),
        .vec_wr_en   (vec_wr_en),
        .vec_wr_idx  (vec_wr_idx),
        .vec_wr_data (vec_wr_data),
        .start       (start),
        .busy        (busy),
        .y_valid     (y_valid),
        .y_idx       (y_idx),
        .y_data      (y_data),
        .y_last      (y_last),
        .done        (done)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic fp_32_t gold(input int r);
        fp_64_t acc;
        acc = 64'sd0;
        for (int j = 0; j < N; j++) begin
            acc = acc + (fp_64_t'(a_m[r][j]) * fp_64_t'(x_m[j]));
        end
        return fp_32_t'(acc >>> Q);
    endfunction

    task automatic wr_mat(input int r, input int c, input logic [31:0] d);
        mat_wr_en = 1'b1; mat_wr_row = 2'(r); mat_wr_col = 2'(c); mat_wr_data = d;
        a_m[r][c] = fp_32_t'(d);
        @(negedge clock);
        mat_wr_en = 1'b0;
    endtask

    task automatic wr_vec(input int j, input logic [31:0] d);
        vec_wr_en = 1'b1; vec_wr_idx = 2'(j); vec_wr_data = d;
        x_m[j] = fp_32_t'(d);
        @(negedge clock);
        vec_wr_en = 1'b0;
    endtask

    task automatic kick(input bit expect_res);
        exp_t e;
        start = 1'b1;
        if (expect_res) begin
            for (int r = 0; r < N; r++) begin
                e.idx = r; e.data = gold(r); e.last = (r == N-1);
                e.cyc = cyc + 2*N + 1 + 2*r;
                sb_q.push_back(e);
            end
        end
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_done(output int busy_cnt);
        int n;
        bit seen;
        n = 0; seen = 1'b0; busy_cnt = 0;
        while (!seen && n < 64) begin
            if (busy) busy_cnt++;
            if (done) seen = 1'b1;
            else begin
                @(negedge clock);
                n++;
            end
        end
        check("done_seen", 64'(seen), 64'd1);
        @(negedge clock);
        check("busy_after_done", 64'(busy), 64'd0);
    endtask

    task automatic load_all(input logic [31:0] diag, input logic [31:0] offd,
                            input logic [31:0] x0, input logic [31:0] xstep);
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                wr_mat(r, c, (r == c) ? diag : offd);
            end
            wr_vec(r, x0 + xstep * 32'(r));
        end
    endtask

    // Monitor: every y_valid must match the head of the scoreboard.
    always @(negedge clock) begin
        exp_t e;
        if (reset_n && y_valid) begin
            if (sb_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_y_valid actual=1 required=0 idx=%0d cycle=%0d", y_idx, cyc);
            end else begin
                e = sb_q.pop_front();
                check("y_idx", 64'(y_idx), 64'(e.idx));
                check("y_data", 64'(y_data), 64'(e.data));
                check("y_last", 64'(y_last), 64'(e.last));
                check("done", 64'(done), 64'(e.last));
                check("y_cycle", 64'(cyc), 64'(e.cyc));
            end
        end else if (y_last || done) begin
            checks++; failures++;
            $display("FAIL stray_last_done actual=%0d%0d required=00 cycle=%0d", y_last, done, cyc);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int r = 0; r < N; r++) begin
            x_m[r] = '0;
            for (int c = 0; c < N; c++) a_m[r][c] = '0;
        end
        repeat (3) @(negedge clock);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_y_valid", 64'(y_valid), 64'd0);
        check("rst_y_last", 64'(y_last), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_y_idx", 64'(y_idx), 64'd0);
        check("rst_y_data", 64'(y_data), 64'd0);
        reset_n = 1'b1;
        @(negedge clock);

        // Identity: y = x, with cycle-exact timing and 15 busy cycles.
        load_all(32'd32768, 32'd0, 32'd32768, 32'd32768);
        kick(1'b1);
        wait_done(bc);
        check("busy_cycles_identity", 64'(bc), 64'd15);

        // All-ones (1.0) times 0.5 -> 2.0 in every row.
        load_all(32'd32768, 32'd32768, 32'd16384, 32'd0);
        kick(1'b1);
        wait_done(bc);

        // Negative diagonal -> -0.5 (0xFFFFC000) in every row.
        load_all(32'hFFFF8000, 32'd0, 32'd16384, 32'd0);
        kick(1'b1);
        wait_done(bc);

        // Random runs, every fourth one back-to-back with unchanged stores.
        for (int run = 0; run < 20; run++) begin
            if ((run % 4) != 3) begin
                for (int r = 0; r < N; r++) begin
                    for (int c = 0; c < N; c++) wr_mat(r, c, $urandom());
                    wr_vec(r, $urandom());
                end
            end
            kick(1'b1);
            wait_done(bc);
            check("busy_cycles_random", 64'(bc), 64'd15);
        end

        // Start and write during RUN are ignored; A[0][0] keeps its old value.
        kick(1'b1);
        repeat (3) @(negedge clock);
        start = 1'b1;
        mat_wr_en = 1'b1; mat_wr_row = 2'd0; mat_wr_col = 2'd0; mat_wr_data = 32'h7FFFFFFF;
        @(negedge clock);
        start = 1'b0; mat_wr_en = 1'b0;
        wait_done(bc);
        repeat (20) @(negedge clock);
        check("no_second_run", 64'(busy), 64'd0);
        kick(1'b1);
        wait_done(bc);

        // Reset at tau=5 aborts; stores are cleared, so the next run gives zeros.
        kick(1'b0);
        repeat (5) @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_y_valid", 64'(y_valid), 64'd0);
        reset_n = 1'b1;
        for (int r = 0; r < N; r++) begin
            x_m[r] = '0;
            for (int c = 0; c < N; c++) a_m[r][c] = '0;
        end
        repeat (30) @(negedge clock);
        kick(1'b1);
        wait_done(bc);

        // Matrix write, vector write and start in the same IDLE cycle.
        mat_wr_en = 1'b1; mat_wr_row = 2'd2; mat_wr_col = 2'd1; mat_wr_data = 32'd65536;
        vec_wr_en = 1'b1; vec_wr_idx = 2'd1; vec_wr_data = 32'd98304;
        a_m[2][1] = 32'sd65536;
        x_m[1] = 32'sd98304;
        kick(1'b1);
        mat_wr_en = 1'b0; vec_wr_en = 1'b0;
        wait_done(bc);

        repeat (20) @(negedge clock);
        check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vs_fp_mat_vec_sequencer.md
Name: vs_fp_mat_vec_sequencer

Overview:
- Controller that owns an N×N fixed-point matrix store and an N-entry vector store, and sequences one square systolic matrix-vector array to compute y = A·x.
- Generates the time-skewed band-diagonal a_in[2N-1] words and the interleaved x_in stream.
- Captures y_out at the exact array cycles and emits the results as an indexed result stream with start/done control.
- Sits between the host/config bus and the vs_fp_square_matrix_vector_mul_array datapath.

Parameters:
Q, 15, fractional bits of fp_32_t; passed to the array.
N, 4, matrix dimension; N ≥ 2.

Ports:
clock  in  1  clock
reset_n  in  1  reset, synchronous, active-low
mat_wr_en  in  1  matrix store write strobe
mat_wr_row  in  $clog2(N)  row index r
mat_wr_col  in  $clog2(N)  column index j
mat_wr_data  in  32  A[r][j], fp_32_t
vec_wr_en  in  1  vector store write strobe
vec_wr_idx  in  $clog2(N)  index j
vec_wr_data  in  32  x[j], fp_32_t
start  in  1  begin a computation
busy  out  1  high while RUN
y_valid  out  1  result word valid (single cycle, no backpressure)
y_idx  out  $clog2(N)  row index of y_data
y_data  out  32  y[r], fp_32_t
y_last  out  1  y_valid for r = N-1
done  out  1  one-cycle pulse, coincident with y_last

Behaviour:
- Reset: state IDLE; busy, y_valid, y_last, done = 0; y_idx, y_data = 0; matrix and vector stores cleared to 0; counter τ = 0. Reset mid-RUN aborts immediately, and no further y_valid is produced.
- Writes: accepted only in IDLE. Writes in RUN are dropped and do not affect the running or any later result. Simultaneous mat_wr_en and vec_wr_en are both performed. Simultaneous write and start in IDLE: the write lands, and the run uses the new value.
- FSM IDLE→RUN when start=1 in IDLE; τ = 0 in the first RUN cycle. start is ignored in RUN. RUN→IDLE after τ = 4N-2. busy = (state==RUN), i.e. 4N-1 cycles.
- Array drive in RUN cycle τ:
  - x_in = x[τ/2] if τ even and τ/2 < N, else 0.
  - For each cell i in 0..2N-2: if (τ+i) even, let k = (τ+i)/2, r = k-(N-1), j = k-i. a_in[i] = A[r][j] if 0 ≤ r < N and 0 ≤ j < N, else 0.
  - a_in[i] = 0 when (τ+i) is odd.
  - In IDLE, all a_in and x_in = 0.
- Array property relied on: its output in cycle t = Σ_i a_i(t-1-i)·x(t-1-2i). Row r therefore appears on the array y_out during τ = 2N-1+2r. All contributing inputs lie within the run, so no flush is needed between runs.
- Capture: registered. y_valid = 1, y_idx = r, y_data = array y_out at τ = 2N+2r. y_last and done are high at τ = 4N-2. y_valid is low on all other cycles.
- Arithmetic (golden model): y[r] = low 32 bits of (Σ_j sext64(A[r][j])·sext64(x[j])) >>> Q. No saturation; wrap in 64-bit accumulation.
- τ counter width $clog2(4N-1). The counter saturates in IDLE at 0.

Decomposition:
- Shared package verisparse.svh holds fp_32_t and fp_64_t; add constant function vs_num_bands(N) = 2N-1 there.
- The one sub-module is vs_fp_square_matrix_vector_mul_array (Q, N), instantiated inside.
- Band/x generation and the FSM stay in this module.

Test Plan:
- N=4, A = identity (diag 32768), x = {32768, 65536, 98304, 131072}, start at cycle c → y_valid at c+9, c+11, c+13, c+15 with y_idx 0..3, y_data = x; y_last and done at c+15; busy high c+1..c+15.
- A all 32768, x all 16384 → every y = 65536; diag A = -32768 with x = {16384,...} → y = -16384 each (0xFFFFC000).
- Random signed A and x over 20 runs, checked against the golden model, including back-to-back runs with start asserted the first IDLE cycle after done.
- During RUN, pulse start and write A[0][0] = 0x7FFFFFFF → current run unchanged, no second run. The next run uses the old A[0][0] (write dropped).
- Reset asserted at τ = 5 → next cycle busy = 0, no y_valid. A subsequent start with no writes → four y_data = 0.
- Simultaneous mat_wr_en, vec_wr_en and start in IDLE → result reflects both new values.
